// File: rtl/sensor_pkg.sv
// sensor_pkg: source indices, arbiter state encoding and the winner-pick helper
// shared by the sensor event scheduler.
`default_nettype none

package sensor_pkg;

  localparam int          N_SRC      = 5;
  localparam logic [2:0]  SRC_FRIO   = 3'd0;
  localparam logic [2:0]  SRC_BANO   = 3'd1;
  localparam logic [2:0]  SRC_CARE   = 3'd2;
  localparam logic [2:0]  SRC_HUNGER = 3'd3;
  localparam logic [2:0]  SRC_DARK   = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Care wins outright; otherwise the first pending source after the last grant.
  function automatic logic [2:0] pick_winner(input logic [N_SRC-1:0] pend,
                                             input logic [2:0]       last);
    logic [2:0] idx;
    logic       found;
    pick_winner = SRC_FRIO;
    found       = 1'b0;
    idx         = last;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (idx == SRC_DARK) ? SRC_FRIO : idx + 3'd1;
      if (!found && pend[idx]) begin
        pick_winner = idx;
        found       = 1'b1;
      end
    end
    if (pend[SRC_CARE]) pick_winner = SRC_CARE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/need_qualifier.sv
// need_qualifier: hold-time qualification, cooldown and pending flag for one
// need source.
`default_nettype none

module need_qualifier
  import sensor_pkg::*;
#(
  parameter int HOLD_CYC     = 50_000_000,
  parameter int COOLDOWN_CYC = 250_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_serve,
  output logic o_pending
);

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int CW = $clog2(COOLDOWN_CYC + 1);
  localparam logic [HW-1:0] c_HOLD_MAX = HW'(HOLD_CYC);
  localparam logic [CW-1:0] c_COOL_MAX = CW'(COOLDOWN_CYC);

  logic [HW-1:0] r_hold;
  logic [CW-1:0] r_cool;
  logic          r_pending;
  logic          w_hold_hit;

  // True when this edge brings (or keeps) the hold counter at its ceiling.
  assign w_hold_hit = i_req && (r_hold >= c_HOLD_MAX - HW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_cool    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (!i_req)
        r_hold <= '0;
      else if (r_hold != c_HOLD_MAX)
        r_hold <= r_hold + HW'(1);

      if (i_serve)
        r_cool <= c_COOL_MAX;
      else if (r_cool != '0)
        r_cool <= r_cool - CW'(1);

      if (i_serve)
        r_pending <= 1'b0;
      else if (w_hold_hit && (r_cool == '0))
        r_pending <= 1'b1;
    end
  end

  assign o_pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/sensor_event_sched.sv
// sensor_event_sched: qualifies sensor need flags and offers them one at a time
// to the behaviour FSM (care first, others round-robin) with an ack timeout.
`default_nettype none

module sensor_event_sched
  import sensor_pkg::*;
#(
  parameter int HOLD_CYC     = 50_000_000,
  parameter int COOLDOWN_CYC = 250_000_000,
  parameter int ACK_TIMEOUT  = 500_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] i_req,
  input  logic             i_ev_ack,
  output logic             o_ev_valid,
  output logic [2:0]       o_ev_id,
  output logic [N_SRC-1:0] o_pending,
  output logic             o_busy,
  output logic [7:0]       o_drop_cnt
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] c_TOUT_LAST = TW'(ACK_TIMEOUT - 1);

  arb_state_t       r_state;
  logic             r_ev_valid;
  logic [2:0]       r_ev_id;
  logic [2:0]       r_last;
  logic             r_busy;
  logic [7:0]       r_drop_cnt;
  logic [TW-1:0]    r_tcnt;
  logic [N_SRC-1:0] w_pending;
  logic [N_SRC-1:0] w_serve;
  logic             w_fire;

  genvar g;
  generate
    for (g = 0; g < N_SRC; g++) begin : g_src
      need_qualifier #(
        .HOLD_CYC     (HOLD_CYC),
        .COOLDOWN_CYC (COOLDOWN_CYC)
      ) u_qual (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req[g]),
        .i_serve   (w_serve[g]),
        .o_pending (w_pending[g])
      );
    end
  endgenerate

  // The offer ends on ack or on the last timeout cycle; either way the source is served.
  assign w_fire = (r_state == OFFER) && (i_ev_ack || (r_tcnt == c_TOUT_LAST));

  always_comb begin
    w_serve = '0;
    if (w_fire) w_serve[r_ev_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ev_valid <= 1'b0;
      r_ev_id    <= 3'd0;
      r_last     <= SRC_DARK;
      r_busy     <= 1'b0;
      r_drop_cnt <= 8'd0;
      r_tcnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_pending) begin
            r_ev_id    <= pick_winner(w_pending, r_last);
            r_ev_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_tcnt     <= '0;
            r_state    <= OFFER;
          end
        end
        OFFER: begin
          if (w_fire) begin
            r_ev_valid <= 1'b0;
            r_ev_id    <= 3'd0;
            r_last     <= r_ev_id;
            if (!i_ev_ack && (r_drop_cnt != 8'hFF))
              r_drop_cnt <= r_drop_cnt + 8'd1;
            r_state    <= GAP;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        GAP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_ev_valid <= 1'b0;
          r_ev_id    <= 3'd0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign o_ev_valid = r_ev_valid;
  assign o_ev_id    = r_ev_id;
  assign o_pending  = w_pending;
  assign o_busy     = r_busy;
  assign o_drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sensor_event_sched.sv
// tb_sensor_event_sched: directed vectors with hand-computed expectations for
// the sensor event scheduler (HOLD=4, COOLDOWN=10, ACK_TIMEOUT=8).
`default_nettype none

module tb_sensor_event_sched;

  logic       clk;
  logic       rst_n;
  logic [4:0] i_req;
  logic       i_ev_ack;
  logic       o_ev_valid;
  logic [2:0] o_ev_id;
  logic [4:0] o_pending;
  logic       o_busy;
  logic [7:0] o_drop_cnt;

  int n_checks;
  int n_errors;

  sensor_event_sched #(
    .HOLD_CYC     (4),
    .COOLDOWN_CYC (10),
    .ACK_TIMEOUT  (8)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req      (i_req),
    .i_ev_ack   (i_ev_ack),
    .o_ev_valid (o_ev_valid),
    .o_ev_id    (o_ev_id),
    .o_pending  (o_pending),
    .o_busy     (o_busy),
    .o_drop_cnt (o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    i_req    = 5'b0;
    i_ev_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (o_ev_valid) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic ack_once();
    i_ev_ack = 1'b1;
    step(1);
    i_ev_ack = 1'b0;
  endtask

  bit ok;
  int exp_order [4] = '{0, 1, 3, 0};

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset state
    rst_n    = 1'b0;
    i_req    = 5'b0;
    i_ev_ack = 1'b0;
    @(negedge clk);
    check("rst_valid",   o_ev_valid, 0);
    check("rst_id",      o_ev_id,    0);
    check("rst_pending", o_pending,  0);
    check("rst_busy",    o_busy,     0);
    check("rst_drop",    o_drop_cnt, 0);

    // Single source: qualify, offer, ack
    do_reset();
    i_req = 5'b00001;
    step(3);
    check("t1_pend_e3", o_pending, 5'b00000);
    step(1);
    check("t1_pend_e4",  o_pending,  5'b00001);
    check("t1_valid_e4", o_ev_valid, 0);
    step(1);
    check("t1_valid_e5", o_ev_valid, 1);
    check("t1_id_e5",    o_ev_id,    0);
    check("t1_busy_e5",  o_busy,     1);
    i_req = 5'b00000;
    ack_once();
    check("t1_valid_ack", o_ev_valid, 0);
    check("t1_pend_ack",  o_pending,  0);

    // Round-robin with all of 0,1,3 held
    do_reset();
    i_req = 5'b01011;
    for (int k = 0; k < 4; k++) begin
      wait_valid(60, ok);
      check($sformatf("t2_offer%0d_seen", k), ok, 1);
      check($sformatf("t2_grant%0d", k), o_ev_id, exp_order[k]);
      ack_once();
      check($sformatf("t2_gap%0d", k), o_ev_valid, 0);
    end

    // Care qualifies during an offer: no pre-emption, but served next
    do_reset();
    i_req = 5'b01001;
    step(2);
    i_req = 5'b01101;
    step(3);
    check("t3_valid_e5", o_ev_valid, 1);
    check("t3_id_e5",    o_ev_id,    0);
    step(1);
    check("t3_pend_e6", o_pending, 5'b01101);
    check("t3_id_e6",   o_ev_id,   0);
    i_req = 5'b00000;
    ack_once();
    wait_valid(10, ok);
    check("t3_care_seen", ok, 1);
    check("t3_care_id",   o_ev_id, 2);
    ack_once();
    wait_valid(10, ok);
    check("t3_hunger_seen", ok, 1);
    check("t3_hunger_id",   o_ev_id, 3);
    ack_once();

    // Timeout drop, then cooldown blocks re-pend for 10 cycles
    do_reset();
    i_req = 5'b00001;
    step(5);
    check("t4_valid_e5", o_ev_valid, 1);
    step(7);
    check("t4_valid_e12", o_ev_valid, 1);
    step(1);
    check("t4_valid_e13", o_ev_valid, 0);
    check("t4_drop_e13",  o_drop_cnt, 1);
    check("t4_pend_e13",  o_pending,  0);
    step(10);
    check("t4_pend_e23", o_pending, 0);
    step(1);
    check("t4_pend_e24", o_pending, 5'b00001);

    // Ack on the timeout edge counts as ack
    do_reset();
    i_req = 5'b00001;
    step(5);
    check("t5_valid_e5", o_ev_valid, 1);
    step(7);
    ack_once();
    check("t5_valid_e13", o_ev_valid, 0);
    check("t5_drop_e13",  o_drop_cnt, 0);
    check("t5_busy_e13",  o_busy,     1);

    // Held request after ack: re-pends right after cooldown with no new hold
    do_reset();
    i_req = 5'b00010;
    step(5);
    check("t6_id_e5", o_ev_id, 1);
    ack_once();
    step(10);
    check("t6_pend_e16",  o_pending,  0);
    check("t6_valid_e16", o_ev_valid, 0);
    step(1);
    check("t6_pend_e17", o_pending, 5'b00010);

    // Reset in the middle of an offer
    do_reset();
    i_req = 5'b00001;
    step(6);
    check("t7_valid_pre", o_ev_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t7_valid_rst", o_ev_valid, 0);
    check("t7_pend_rst",  o_pending,  0);
    check("t7_busy_rst",  o_busy,     0);
    check("t7_drop_rst",  o_drop_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check("t7_pend_e3", o_pending, 0);
    step(1);
    check("t7_pend_e4", o_pending, 5'b00001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sensor_event_sched.md
# sensor_event_sched

Scheduler between the sensor front end (cold, bathroom, care/distance, hunger, darkness flags) and the pet behaviour FSM. Each flag is qualified by a hold time and a per-source cooldown. Qualified needs are arbitrated: care has strict priority, all other sources are served round-robin. The block delivers one event at a time over a valid/ack handshake with an ack timeout, so the FSM never sees two needs at once or a need re-fired immediately.

## Interface
- HOLD_CYC, 50_000_000: consecutive cycles a request must stay high before it becomes pending.
- COOLDOWN_CYC, 250_000_000: cycles a source is blocked after its event is acked or dropped.
- ACK_TIMEOUT, 500_000_000: cycles an offered event waits for ack before it is dropped.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  5  need levels: bit0 frio, bit1 bano, bit2 care, bit3 hunger (inverted eat), bit4 dark (inverted light).
- ev_ack  in  1  behaviour FSM accepts the offered event.
- ev_valid  out  1  event offered.
- ev_id  out  3  source index 0..4 while ev_valid; 0 otherwise.
- pending  out  5  qualified, not-yet-served needs.
- busy  out  1  arbiter not in IDLE.
- drop_cnt  out  8  count of timed-out events; saturates at 255.

## Operation
- Reset values: ev_valid=0, ev_id=0, pending=0, busy=0, drop_cnt=0. All hold counters and cooldowns are 0. last_grant=4. State is IDLE.
- Hold counter per source:
  - while req[i]=1 it increments, saturating at HOLD_CYC.
  - when req[i]=0 it clears to 0. This does not clear pending[i].
- pending[i] sets when the hold counter reaches HOLD_CYC and cooldown[i]=0.
- If req stays high through a cooldown, pending sets on the first cycle after the cooldown reaches 0. The saturated counter is reused and no fresh hold period is required.
- Setting an already-set pending bit has no effect.
- Cooldown[i] loads COOLDOWN_CYC on ack or drop of source i. It decrements to 0 and never wraps.
- FSM states:
  - IDLE: if pending != 0, pick the winner, register ev_id, set ev_valid, go to OFFER.
  - Winner rule: pending[2] wins outright. Otherwise the first set bit scanning upward from last_grant+1, modulo 5.
  - OFFER: ev_valid and ev_id are held stable. The timeout counter increments.
    - If ev_ack=1: clear pending[id], load its cooldown, set last_grant=id, go to GAP.
    - Else if the timeout counter = ACK_TIMEOUT-1: drop the event. Clear pending[id], load its cooldown, increment drop_cnt (saturating), set last_grant=id, go to GAP.
  - GAP: one cycle with ev_valid=0, then IDLE.
- Ack and timeout on the same cycle: ack wins and drop_cnt is unchanged.
- ev_ack outside OFFER is ignored.
- New pending bits arriving during OFFER/GAP do not pre-empt the offer. This includes care.
- Reset asserted mid-OFFER returns every output and counter to its reset value immediately. No event is reported.

## Timing
- With req[i] high from edge 1, pending[i] reads 1 after edge HOLD_CYC.
- ev_valid rises one edge after pending becomes nonzero while in IDLE.
- The ack edge clears ev_valid and pending[id] together.
- The earliest next ev_valid is 2 edges after the ack edge: GAP, then IDLE registers the grant.
- Drop occurs on the ACK_TIMEOUT-th edge in OFFER.
- All outputs are registered. There is no combinational path from req or ev_ack to any output.

## Structure
- Shared package sensor_pkg holds:
  - source index constants SRC_FRIO=0, SRC_BANO=1, SRC_CARE=2, SRC_HUNGER=3, SRC_DARK=4, and N_SRC=5;
  - the arbiter state enum {IDLE, OFFER, GAP}.
- Sub-module need_qualifier: one hold counter, one cooldown counter and the pending bit per source, instantiated N_SRC times. Its ports are:
  - inputs: clk, reset, req, serve (load cooldown and clear pending);
  - output: pending.
- Top level contains the winner selection, the FSM, the timeout counter and drop_cnt.

## Test plan
Parameters: HOLD_CYC=4, COOLDOWN_CYC=10, ACK_TIMEOUT=8.
- req=5'b00001 for 4 edges -> pending=5'b00001 after edge 4, ev_valid=1 with ev_id=0 after edge 5. Ack on the next edge -> ev_valid=0 and pending=0.
- req=5'b01011 held, ack every offer -> grant order 0, 1, 3, 0 (after cooldown), with ev_valid low for at least one cycle between events.
- pending bits 0 and 3 set, then req[2] qualifies while event 0 is in OFFER -> 0 completes, then the next grant is ev_id=2, before 3.
- Offer with no ack -> after 8 edges ev_valid=0, drop_cnt=1, that source blocked for 10 cycles. Ack asserted on edge 8 -> treated as ack, drop_cnt stays 0.
- req[1] held high continuously after ack -> no re-offer for 10 cycles. pending[1] sets on the first cycle after cooldown reaches 0 with no new hold period.
- Reset asserted mid-OFFER and released -> ev_valid=0, pending=0, drop_cnt=0, busy=0 immediately. Re-qualification requires a full 4-cycle hold.
